// File: rtl/param_acc_core.sv
// param_acc_core -- small accumulator processor with a unified program/data
// memory of 2**ADDR_W words, each DATA_W bits wide.
//
// Every instruction takes three steps: FETCH, DECODE and EXEC. An IN
// instruction can add extra EXEC cycles while it waits for in_valid. HALT
// returns the core to IDLE. While the core is in IDLE, the memory can be
// loaded through the prog_* port.
//
// Ports
//   clock      single clock; all state changes on the rising edge
//   reset      asynchronous active-high reset (state, A, PC, IR)
//   start      one-cycle request to run from address 0 (only seen in IDLE)
//   prog_we    memory write enable (only honoured in IDLE)
//   prog_addr  memory write address
//   prog_data  memory write data
//   in_data    operand for IN
//   in_valid   in_data is valid
//   in_ready   high while an IN waits in EXEC
//   out_data   accumulator A
//   Aeq0       A == 0
//   Apos       A != 0 and the sign bit of A is clear
//   ir         opcode field of the instruction register
//   pc         program counter
//   busy       high in every state except IDLE
module param_acc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              Aeq0,
  output logic              Apos,
  output logic [2:0]        ir,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [2:0]          opcode_s;
  logic [ADDR_W-1:0]   op_addr_s;
  logic [DATA_W-1:0]   operand_s;
  logic                aeq0_s;
  logic                apos_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic                in_ready_s;
  logic                busy_s;

  assign opcode_s  = ir_q[DATA_W-1 -: 3];
  assign op_addr_s = ir_q[ADDR_W-1:0];
  assign operand_s = mem_q[op_addr_s];
  assign aeq0_s    = (a_q == {DATA_W{1'b0}});
  assign apos_s    = !aeq0_s && !a_q[DATA_W-1];

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= {DATA_W{1'b0}};
      pc_q    <= {ADDR_W{1'b0}};
      ir_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Memory: synchronous write with no reset. The contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode_s)
          OP_HALT: state_d = S_IDLE;
          OP_IN: begin
            if (in_valid) state_d = S_FETCH;
            else          state_d = S_EXEC;
          end
          default: state_d = S_FETCH;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic for each state.
  always_comb begin
    a_d         = a_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = prog_addr;
    mem_wdata_s = prog_data;
    in_ready_s  = 1'b0;
    busy_s      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_s = 1'b0;
        // A program write on the same edge as start still completes.
        mem_we_s = prog_we && !reset;
        if (start) pc_d = {ADDR_W{1'b0}};
        else       pc_d = pc_q;
      end
      S_FETCH: begin
        ir_d = mem_q[pc_q];
        pc_d = pc_q + PC_ONE;   // wraps naturally at 2**ADDR_W
      end
      S_DECODE: begin
        pc_d = pc_q;
      end
      S_EXEC: begin
        case (opcode_s)
          OP_LOAD:  a_d = operand_s;
          OP_STORE: begin
            mem_we_s    = !reset;
            mem_waddr_s = op_addr_s;
            mem_wdata_s = a_q;
          end
          OP_ADD:   a_d = a_q + operand_s;
          OP_SUB:   a_d = a_q - operand_s;
          OP_IN: begin
            in_ready_s = 1'b1;
            if (in_valid) a_d = in_data;
            else          a_d = a_q;
          end
          OP_JZ: begin
            if (aeq0_s) pc_d = op_addr_s;
            else        pc_d = pc_q;
          end
          OP_JPOS: begin
            if (apos_s) pc_d = op_addr_s;
            else        pc_d = pc_q;
          end
          OP_HALT:  a_d = a_q;
          default:  a_d = a_q;
        endcase
      end
      default: busy_s = 1'b0;
    endcase
  end

  assign in_ready = in_ready_s;
  assign busy     = busy_s;
  assign out_data = a_q;
  assign Aeq0     = aeq0_s;
  assign Apos     = apos_s;
  assign ir       = opcode_s;
  assign pc       = pc_q;

endmodule

// File: doc/param_acc_core.md
PARAM_ACC_CORE -- requirements
Module: param_acc_core

Interface
REQ-001 Parameter DATA_W, default 8: width of the accumulator, memory words and in_data/out_data; legal only if DATA_W >= ADDR_W+3.
REQ-002 Parameter ADDR_W, default 5: width of the PC and address fields; memory depth is 2**ADDR_W words.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin execution at address 0.
REQ-006 prog_we  input  1  program-memory write enable.
REQ-007 prog_addr  input  ADDR_W  program-memory write address.
REQ-008 prog_data  input  DATA_W  program-memory write data.
REQ-009 in_data  input  DATA_W  operand for the IN instruction.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  core is accepting in_data.
REQ-012 out_data  output  DATA_W  accumulator A value.
REQ-013 Aeq0  output  1  A == 0.
REQ-014 Apos  output  1  A != 0 and A[DATA_W-1] == 0.
REQ-015 ir  output  3  opcode field of the instruction register.
REQ-016 pc  output  ADDR_W  program counter.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Instruction word: opcode = bits [DATA_W-1:DATA_W-3]; addr = bits [ADDR_W-1:0]; bits between them are ignored.
REQ-019 Opcodes: 000 LOAD A<=M[addr]; 001 STORE M[addr]<=A; 010 ADD A<=A+M[addr]; 011 SUB A<=A-M[addr]; 100 IN; 101 JZ (PC<=addr if Aeq0); 110 JPOS (PC<=addr if Apos); 111 HALT.
REQ-020 Memory is written synchronously and read asynchronously; reset does not clear it.
REQ-021 prog_we is honoured only in IDLE and ignored in all other states.
REQ-022 FSM states are IDLE, FETCH, DECODE and EXEC.
REQ-023 IDLE: start=1 -> FETCH with PC<=0; otherwise remain in IDLE; a prog_we on the same edge as start still completes.
REQ-024 FETCH: IR<=M[PC] and PC<=PC+1 modulo 2**ADDR_W (address 2**ADDR_W-1 wraps to 0), then go to DECODE.
REQ-025 DECODE: no register changes; go to EXEC after one cycle.
REQ-026 EXEC executes the opcode and goes to FETCH, except for HALT and for IN while stalled.
REQ-027 HALT -> IDLE; A, PC and IR are held.
REQ-028 IN: in_ready=1 only in EXEC with opcode 100; if in_valid=1 then A<=in_data and go to FETCH, else stay in EXEC; in_ready is 0 in all other states.
REQ-029 ADD/SUB are modulo 2**DATA_W; carry and borrow are discarded.
REQ-030 Aeq0 and Apos are combinational from the current A.
REQ-031 A jump whose condition is false leaves PC at the incremented value.
REQ-032 start outside IDLE is ignored.
REQ-033 An instruction takes 3 cycles (FETCH, DECODE, EXEC), plus one cycle per stall in IN.

Reset
REQ-034 While reset=1, asynchronously: state=IDLE, A=0, PC=0, IR=0, in_ready=0, busy=0; hence Aeq0=1 and Apos=0.
REQ-035 Reset asserted mid-instruction aborts the instruction; a STORE not yet clocked is not written.

Verification
REQ-036 LOAD: DATA_W=8, ADDR_W=5; M[0]=0x0A, M[1]=0xE0, M[10]=0x8B; start -> A=0x8B, Aeq0=0, Apos=0; busy falls 6 cycles after start.
REQ-037 SUB/STORE/JZ: program LOAD 10, SUB 10, STORE 11, JZ 5, at address 5 HALT -> M[11]=0x00, Aeq0=1, jump taken, final pc=6.
REQ-038 IN stall: IN with in_valid low for 4 cycles, then in_data=0x05 with in_valid=1 -> in_ready held high 5 cycles, A=0x05, Apos=1.
REQ-039 ADD wrap: A=0xFF, ADD of a word holding 0x02 -> A=0x01; PC at 31 after FETCH wraps to 0.
REQ-040 Reset mid-op: reset asserted during EXEC of a STORE -> memory unchanged, busy=0, A=0, pc=0 immediately, without waiting for a clock edge.
REQ-041 Illegal timing: prog_we while busy -> memory unchanged; start while busy -> execution unaffected.
